// File: rtl/pio_arb_pkg.sv
// Shared types and defaults for the two-requester PIO port arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pio_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    // Command sequencer states: single-cycle write strobe, single-cycle read
    // strobe, then one wait cycle while the registered slave data settles.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RDW  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection.
// Latency: combinational.
// Backpressure: none; the grant is only meaningful when some valid is high.
// Ports: valid[1:0] request vector, last_grant = index granted last,
//        grant = index that wins this cycle.
module rr_arbiter2
    import pio_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_grant,
    output logic               grant
);

    always_comb begin
        grant = ~last_grant;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // Tie (or nothing requesting): the requester not served last wins.
            default: grant = ~last_grant;
        endcase
    end

endmodule

// File: rtl/pio_port_arbiter.sv
// Shares one Avalon-MM PIO slave between two command requesters, round-robin.
// Latency: write strobe 1 cycle after accept; read rsp_valid 3 cycles after accept.
// Backpressure: rX_ready is high only in IDLE for the granted, valid requester.
// Ports: r0_*/r1_* command request + ready + rsp_valid, shared rsp_readdata,
//        pio_* Avalon-MM master, busy = sequencer not idle.
module pio_port_arbiter
    import pio_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_ready,
    output logic              r0_rsp_valid,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_ready,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic [ADDR_W-1:0] pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [DATA_W-1:0] pio_writedata,
    input  logic [DATA_W-1:0] pio_readdata,
    output logic              busy
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                pio_cs_q, pio_cs_d;
    logic                pio_write_n_q, pio_write_n_d;
    logic [ADDR_W-1:0]   pio_address_q, pio_address_d;
    logic [DATA_W-1:0]   pio_writedata_q, pio_writedata_d;
    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_readdata_q, rsp_readdata_d;

    logic [NUM_REQ-1:0]  req_vld;
    logic                grant;
    logic                can_accept;
    logic                accept;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W-1:0]   sel_writedata;

    assign req_vld = {r1_valid, r0_valid};

    rr_arbiter2 u_arb (
        .valid      (req_vld),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Reset gates ready so nothing is accepted while reset is held.
    assign can_accept = !reset && (state_q == IDLE);
    assign r0_ready   = can_accept && r0_valid && !grant;
    assign r1_ready   = can_accept && r1_valid &&  grant;
    assign accept     = r0_ready || r1_ready;

    assign sel_write     = grant ? r1_write     : r0_write;
    assign sel_address   = grant ? r1_address   : r0_address;
    assign sel_writedata = grant ? r1_writedata : r0_writedata;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        // Bus outputs fall back to idle values unless a strobe is being launched.
        pio_cs_d        = 1'b0;
        pio_write_n_d   = 1'b1;
        pio_address_d   = '0;
        pio_writedata_d = '0;
        rsp_vld_d       = '0;
        rsp_readdata_d  = rsp_readdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d    = grant;
                    owner_d         = grant;
                    state_d         = sel_write ? WR : RD;
                    // The accepted command is registered straight into the bus
                    // flops so the strobe appears in the very next cycle.
                    pio_cs_d        = 1'b1;
                    pio_write_n_d   = !sel_write;
                    pio_address_d   = sel_address;
                    pio_writedata_d = sel_write ? sel_writedata : '0;
                end
            end
            WR: state_d = IDLE;
            RD: state_d = RDW;
            RDW: begin
                // Slave data is registered, so it is valid during RDW.
                state_d           = IDLE;
                rsp_readdata_d    = pio_readdata;
                rsp_vld_d[owner_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            owner_q         <= 1'b0;
            pio_cs_q        <= 1'b0;
            pio_write_n_q   <= 1'b1;
            pio_address_q   <= '0;
            pio_writedata_q <= '0;
            rsp_vld_q       <= '0;
            rsp_readdata_q  <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            pio_cs_q        <= pio_cs_d;
            pio_write_n_q   <= pio_write_n_d;
            pio_address_q   <= pio_address_d;
            pio_writedata_q <= pio_writedata_d;
            rsp_vld_q       <= rsp_vld_d;
            rsp_readdata_q  <= rsp_readdata_d;
        end
    end

    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = pio_write_n_q;
    assign pio_address    = pio_address_q;
    assign pio_writedata  = pio_writedata_q;
    assign r0_rsp_valid   = rsp_vld_q[0];
    assign r1_rsp_valid   = rsp_vld_q[1];
    assign rsp_readdata   = rsp_readdata_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_pio_port_arbiter.sv
// Bench for pio_port_arbiter: directed scenarios then random traffic.
// Latency: expectations are derived from accept cycle numbers.
// Backpressure: requesters hold valid and fields until accepted.
module tb_pio_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic          r0_write = 1'b0, r1_write = 1'b0;
    logic [AW-1:0] r0_address = '0, r1_address = '0;
    logic [DW-1:0] r0_writedata = '0, r1_writedata = '0;
    logic          r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
    logic [DW-1:0] rsp_readdata;
    logic [AW-1:0] pio_address;
    logic          pio_chipselect, pio_write_n;
    logic [DW-1:0] pio_writedata;
    logic [DW-1:0] pio_readdata;
    logic          busy;

    always #5 clk = ~clk;

    pio_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_address(r0_address),
        .r0_writedata(r0_writedata), .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_address(r1_address),
        .r1_writedata(r1_writedata), .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid),
        .rsp_readdata(rsp_readdata),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata), .busy(busy)
    );

    // PIO slave: register file with registered read data; cleared by reset.
    logic [DW-1:0] slave_mem [4];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) slave_mem[i] <= '0;
            pio_readdata <= '0;
        end else begin
            if (pio_chipselect && !pio_write_n) slave_mem[pio_address] <= pio_writedata;
            if (pio_chipselect &&  pio_write_n) pio_readdata <= slave_mem[pio_address];
        end
    end

    // Transaction-level reference: everything follows from the accept cycle.
    int            cyc = 0;
    int            acc_cyc = -100, free_at = 0, rsp_cyc = -100;
    bit            m_last = 1'b1, m_write = 1'b0, rsp_owner = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, rsp_data = '0, exp_rdata = '0;
    logic [DW-1:0] model_mem [4];
    int            grant_log [$];
    bit [1:0]      last_acc;
    int            acc_at [2];
    int            rsp1_cyc = -1, rsp_seen = 0, cs_seen = 0;
    logic [DW-1:0] rsp1_data = '0, cs_wdata = '0;

    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        bit       win, strobe;
        bit [1:0] exp_rdy;
        @(negedge clk);
        win = (r0_valid && r1_valid) ? ~m_last : (r1_valid && !r0_valid);
        exp_rdy = 2'b00;
        if (!reset && cyc >= free_at && (r0_valid || r1_valid)) exp_rdy[win] = 1'b1;
        strobe = (cyc == acc_cyc + 1);
        if (cyc == rsp_cyc) exp_rdata = rsp_data;
        chk("r0_ready", r0_ready, exp_rdy[0]);
        chk("r1_ready", r1_ready, exp_rdy[1]);
        chk("busy", busy, (cyc > acc_cyc && cyc < free_at));
        chk("pio_chipselect", pio_chipselect, strobe);
        chk("pio_write_n", pio_write_n, !(strobe && m_write));
        chk("pio_address", pio_address, strobe ? m_addr : '0);
        chk("pio_writedata", pio_writedata, (strobe && m_write) ? m_data : '0);
        chk("r0_rsp_valid", r0_rsp_valid, (cyc == rsp_cyc && rsp_owner == 1'b0));
        chk("r1_rsp_valid", r1_rsp_valid, (cyc == rsp_cyc && rsp_owner == 1'b1));
        chk("rsp_readdata", rsp_readdata, exp_rdata);
        if (pio_chipselect) begin cs_seen++; cs_wdata = pio_writedata; end
        if (r0_rsp_valid || r1_rsp_valid) rsp_seen++;
        if (r1_rsp_valid) begin rsp1_cyc = cyc; rsp1_data = rsp_readdata; end
        @(posedge clk);
        last_acc = 2'b00;
        if (reset) begin
            acc_cyc = -100; free_at = 0; rsp_cyc = -100; m_last = 1'b1; exp_rdata = '0;
            for (int i = 0; i < 4; i++) model_mem[i] = '0;
        end else if (exp_rdy != 2'b00) begin
            last_acc = exp_rdy;
            acc_at[win] = cyc;
            acc_cyc = cyc;
            m_last = win;
            grant_log.push_back(int'(win));
            m_write = win ? r1_write : r0_write;
            m_addr  = win ? r1_address : r0_address;
            m_data  = win ? r1_writedata : r0_writedata;
            if (m_write) begin
                model_mem[m_addr] = m_data;
                free_at = cyc + 2;
            end else begin
                free_at = cyc + 3;
                rsp_cyc = cyc + 3;
                rsp_owner = win;
                rsp_data = model_mem[m_addr];
            end
        end
        cyc++;
        #1;
        if (last_acc[0]) r0_valid = 1'b0;
        if (last_acc[1]) r1_valid = 1'b0;
    endtask

    task automatic issue(input int r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin r0_valid = 1'b1; r0_write = w; r0_address = a; r0_writedata = d; end
        else        begin r1_valid = 1'b1; r1_write = w; r1_address = a; r1_writedata = d; end
    endtask

    task automatic wait_acc(input int r);
        int n = 0;
        while (((r == 0) ? r0_valid : r1_valid) && n < 20) begin tick(); n++; end
        chk(r == 0 ? "accept_timeout_r0" : "accept_timeout_r1", n < 20, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int base, c0, n;
        for (int i = 0; i < 4; i++) model_mem[i] = '0;

        // Reset state.
        idle(2);
        reset = 1'b0;
        idle(1);

        // Single write by r0: exactly one write strobe carrying 0xA5.
        cs_seen = 0;
        issue(0, 1'b1, 2'd0, 32'h0000_00A5);
        wait_acc(0);
        idle(4);
        chk("wr_a5_strobe_count", cs_seen, 1);
        chk("wr_a5_wdata", cs_wdata, 32'h0000_00A5);

        // Slave now returns 0x3C at addr 0; r1 reads it back.
        issue(0, 1'b1, 2'd0, 32'h0000_003C);
        wait_acc(0);
        idle(1);
        rsp1_cyc = -1;
        issue(1, 1'b0, 2'd0, '0);
        wait_acc(1);
        idle(5);
        chk("rd_rsp_latency", rsp1_cyc - acc_at[1], 3);
        chk("rd_rsp_data", rsp1_data, 32'h0000_003C);

        // Both requesters valid continuously from reset: strict alternation.
        reset = 1'b1;
        issue(0, 1'b1, 2'd1, 32'h1111_0000);
        issue(1, 1'b0, 2'd1, '0);
        tick();
        reset = 1'b0;
        grant_log.delete();
        n = 0;
        while (grant_log.size() < 8 && n < 60) begin
            tick();
            n++;
            if (!r0_valid) issue(0, 1'b1, 2'(n), $urandom);
            if (!r1_valid) issue(1, 1'b0, 2'(n), '0);
        end
        chk("alt_grant_count", grant_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("alt_grant_order", grant_log[i], i % 2);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        idle(4);

        // Reset during RD: no response, bus idle afterwards.
        issue(0, 1'b0, 2'd2, '0);
        wait_acc(0);
        reset = 1'b1;
        rsp_seen = 0;
        tick();
        reset = 1'b0;
        idle(4);
        chk("rd_abort_no_rsp", rsp_seen, 0);

        // Back-to-back r0 writes accepted every second cycle.
        issue(0, 1'b1, 2'd3, 32'hCAFE_0001);
        wait_acc(0);
        for (int i = 0; i < 3; i++) begin
            c0 = acc_at[0];
            issue(0, 1'b1, 2'd3, 32'hCAFE_0002 + i);
            wait_acc(0);
            chk("b2b_write_spacing", acc_at[0] - c0, 2);
        end
        idle(3);

        // Random traffic, with occasional resets.
        base = cyc;
        while (cyc - base < 600) begin
            if (!r0_valid && $urandom_range(0, 2) == 0)
                issue(0, 1'($urandom), 2'($urandom), $urandom);
            if (!r1_valid && $urandom_range(0, 2) == 0)
                issue(1, 1'($urandom), 2'($urandom), $urandom);
            reset = ($urandom_range(0, 79) == 0);
            tick();
            reset = 1'b0;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        idle(5);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pio_port_arbiter.md
PIO_PORT_ARBITER -- requirements
Module: pio_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data width of the PIO slave port.
REQ-002 The block SHALL have parameter ADDR_W, default 2, meaning PIO register address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports r0_valid / r1_valid, input, 1 bit each: command request.
REQ-006 The block SHALL have ports r0_write / r1_write, input, 1 bit each: 1 = write, 0 = read.
REQ-007 The block SHALL have ports r0_address / r1_address, input, ADDR_W each: target register.
REQ-008 The block SHALL have ports r0_writedata / r1_writedata, input, DATA_W each: write data.
REQ-009 The block SHALL have ports r0_ready / r1_ready, output, 1 bit each: command accepted this cycle.
REQ-010 The block SHALL have ports r0_rsp_valid / r1_rsp_valid, output, 1 bit each: one-cycle read-data pulse.
REQ-011 The block SHALL have port rsp_readdata, output, DATA_W: read data, valid while an rsp_valid is high.
REQ-012 The block SHALL have ports pio_address (ADDR_W), pio_chipselect (1), pio_write_n (1) and pio_writedata (DATA_W), all outputs: Avalon-MM master to the PIO slave.
REQ-013 The block SHALL have port pio_readdata, input, DATA_W: registered slave read data.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WR, RD, RDW.
REQ-016 In IDLE, a command SHALL be accepted when rX_valid and grant==X; rX_ready SHALL be combinational, high only in IDLE for the granted requester.
REQ-017 Arbitration SHALL be round-robin: on simultaneous valids the requester not granted last wins; with a single valid, that requester wins.
REQ-018 On accept, the command fields SHALL be registered, last_grant SHALL update, and the FSM SHALL go to WR (write) or RD (read).
REQ-019 WR: pio_chipselect=1, pio_write_n=0, with address/writedata held for exactly one cycle; then IDLE.
REQ-020 RD: pio_chipselect=1, pio_write_n=1, with address held for one cycle; then RDW.
REQ-021 RDW: pio_chipselect=0; pio_readdata SHALL be captured into rsp_readdata at the end of RDW; rX_rsp_valid for the owning requester SHALL be high for exactly the next cycle.
REQ-022 Latency: write strobe in cycle N+1 after accept in cycle N, next accept possible at N+2; read rsp_valid in cycle N+3, next accept possible at N+3.
REQ-023 Outside WR/RD, outputs SHALL be pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-024 A requester SHALL hold valid and fields stable until ready; a deasserted valid in IDLE SHALL NOT be accepted.
REQ-025 rsp_readdata SHALL hold its last captured value between responses.

Reset
REQ-026 Reset SHALL force: state=IDLE, last_grant=1 (requester 0 wins first tie), all rX_ready/rX_rsp_valid=0, busy=0, rsp_readdata=0, and pio outputs per REQ-023.
REQ-027 Reset asserted mid-operation SHALL abort it: no strobe in the following cycle and no rsp_valid pulse afterwards.
REQ-028 While reset is high, no command SHALL be accepted.

Structure
REQ-029 Package pio_arb_pkg SHALL hold the state enum (IDLE/WR/RD/RDW), NUM_REQ=2, and default widths.
REQ-030 Sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant (inputs valid[1:0], last_grant; output grant).

Verification
REQ-031 A write by r0 to addr 0 of 0x000000A5 SHALL produce pio_chipselect=1, pio_write_n=0, pio_writedata=0xA5 for one cycle only.
REQ-032 With the slave model returning 0x3C, a read by r1 at addr 0 SHALL produce r1_rsp_valid for one cycle, 3 cycles after accept, with rsp_readdata=0x3C.
REQ-033 With r0 and r1 valid continuously from reset, grants SHALL alternate r0, r1, r0, r1 with no starvation.
REQ-034 Reset asserted in RD SHALL return the block to IDLE with no rsp_valid pulse and pio_chipselect=0 next cycle.
REQ-035 Back-to-back r0 writes SHALL be accepted every 2 cycles and r0_ready SHALL be 0 in WR.
